float_mul_param: RTL

- Parametrised multi-cycle IEEE-754-style floating-point multiplier; successor to the fixed single-precision multiplier in the inverse-square-root datapath.
- Generalised in exponent and mantissa width. Adds:
  - sign handling
  - round-to-nearest-even
  - zero, infinity and NaN handling
  - overflow and underflow saturation, with status flags
  - a busy indication for upstream flow control.

---
 rtl/float_mul_param.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/float_mul_param.sv
// Parametrised multi-cycle floating-point multiplier with RNE rounding,
// special-case handling, saturation flags and a busy/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      request, sampled only while idle
//   float_in_1 operand A {sign, exp, man}
//   float_in_2 operand B {sign, exp, man}
//   float_out  product, held until the next result
//   ready      one-cycle pulse when float_out is updated
//   busy       high while an operation is in flight
//   overflow   result saturated to infinity (valid with ready, held)
//   underflow  result flushed to zero (valid with ready, held)
//   invalid    NaN produced (valid with ready, held)
module float_mul_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [EXP_W+MAN_W:0] float_in_1,
  input  logic [EXP_W+MAN_W:0] float_in_2,
  output logic [EXP_W+MAN_W:0] float_out,
  output logic               ready,
  output logic               busy,
  output logic               overflow,
  output logic               underflow,
  output logic               invalid
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;

  localparam logic signed [EW-1:0] BIAS =
    EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX =
    EW'((1 << EXP_W) - 1);

  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, MUL, NORM, ROUND, FINISH
  } state_t;

  typedef enum logic [1:0] {
    SP_NONE, SP_NAN, SP_INF, SP_ZERO
  } spec_t;

  state_t state;

  logic [W-1:0]           a_q;
  logic [W-1:0]           b_q;
  logic                   sign_q;
  logic signed [EW-1:0]   exp_q;
  logic [PW-1:0]          prod_q;
  spec_t                  spec_q;
  logic [MAN_W-1:0]       frac_q;
  logic                   guard_q;
  logic                   sticky_q;

  logic [EXP_W-1:0] ea;
  logic [EXP_W-1:0] eb;
  logic [MAN_W-1:0] ma;
  logic [MAN_W-1:0] mb;

  assign ea = a_q[W-2:MAN_W];
  assign eb = b_q[W-2:MAN_W];
  assign ma = a_q[MAN_W-1:0];
  assign mb = b_q[MAN_W-1:0];

  // MUL stage: classify, exponent sum, mantissa product
  logic                 nan_a, nan_b;
  logic                 inf_a, inf_b;
  logic                 zro_a, zro_b;
  spec_t                m_spec;
  logic signed [EW-1:0] m_exp;
  logic [PW-1:0]        m_ma;
  logic [PW-1:0]        m_mb;
  logic [PW-1:0]        m_prod;

  always_comb begin
    nan_a = (&ea) && (ma != '0);
    nan_b = (&eb) && (mb != '0);
    inf_a = (&ea) && (ma == '0);
    inf_b = (&eb) && (mb == '0);
    // Denormals are flushed, so exp == 0 means zero.
    zro_a = (ea == '0);
    zro_b = (eb == '0);
    m_spec = SP_NONE;
    if (nan_a || nan_b)
      m_spec = SP_NAN;
    else if ((inf_a && zro_b) || (zro_a && inf_b))
      m_spec = SP_NAN;
    else if (inf_a || inf_b)
      m_spec = SP_INF;
    else if (zro_a || zro_b)
      m_spec = SP_ZERO;
    m_exp = $signed({2'b00, ea})
          + $signed({2'b00, eb})
          - BIAS;
    m_ma = PW'({1'b1, ma});
    m_mb = PW'({1'b1, mb});
    m_prod = m_ma * m_mb;
  end

  // NORM stage: product lies in [1,4); pick the hidden-bit position
  logic [MAN_W-1:0]     n_frac;
  logic                 n_guard;
  logic                 n_sticky;
  logic signed [EW-1:0] n_exp;

  always_comb begin
    n_frac   = prod_q[PW-3 -: MAN_W];
    n_guard  = prod_q[MAN_W-1];
    n_sticky = |prod_q[MAN_W-2:0];
    n_exp    = exp_q;
    if (prod_q[PW-1]) begin
      n_frac   = prod_q[PW-2 -: MAN_W];
      n_guard  = prod_q[MAN_W];
      n_sticky = |prod_q[MAN_W-1:0];
      n_exp    = exp_q + EW'(1);
    end
  end

  // ROUND stage: round to nearest, ties to even
  logic                 r_inc;
  logic [MAN_W:0]       r_sum;
  logic signed [EW-1:0] r_exp;

  always_comb begin
    r_inc = guard_q & (sticky_q | frac_q[0]);
    r_sum = {1'b0, frac_q} + (MAN_W+1)'(r_inc);
    // Carry out leaves the fraction at zero, i.e. 1.0 * 2^(e+1).
    r_exp = exp_q + EW'(r_sum[MAN_W]);
  end

  // FINISH stage: pack result and flags
  logic [W-1:0] f_out;
  logic         f_ovf;
  logic         f_unf;
  logic         f_inv;

  always_comb begin
    f_out = {sign_q, exp_q[EXP_W-1:0], frac_q};
    f_ovf = 1'b0;
    f_unf = 1'b0;
    f_inv = 1'b0;
    unique case (spec_q)
      SP_NAN: begin
        f_out = QNAN;
        f_inv = 1'b1;
      end
      SP_INF: begin
        f_out = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
      SP_ZERO: begin
        f_out = {sign_q, {(W-1){1'b0}}};
      end
      default: begin
        if (exp_q >= EMAX) begin
          f_out = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          f_ovf = 1'b1;
        end else if (exp_q[EW-1] || exp_q == '0) begin
          f_out = {sign_q, {(W-1){1'b0}}};
          f_unf = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      prod_q    <= '0;
      spec_q    <= SP_NONE;
      frac_q    <= '0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      float_out <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q   <= float_in_1;
            b_q   <= float_in_2;
            busy  <= 1'b1;
            state <= MUL;
          end
        end
        MUL: begin
          sign_q <= a_q[W-1] ^ b_q[W-1];
          exp_q  <= m_exp;
          prod_q <= m_prod;
          spec_q <= m_spec;
          state  <= NORM;
        end
        NORM: begin
          frac_q   <= n_frac;
          guard_q  <= n_guard;
          sticky_q <= n_sticky;
          exp_q    <= n_exp;
          state    <= ROUND;
        end
        ROUND: begin
          frac_q <= r_sum[MAN_W-1:0];
          exp_q  <= r_exp;
          state  <= FINISH;
        end
        FINISH: begin
          // First FINISH cycle writes, second one is the ready cycle.
          if (!ready) begin
            float_out <= f_out;
            overflow  <= f_ovf;
            underflow <= f_unf;
            invalid   <= f_inv;
            ready     <= 1'b1;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
